// File: rtl/vram_port_arbiter_if.sv
// Bundle of the three requester ports and the single VRAM port served by vram_port_arbiter.
// The master side holds the requesters and the RAM macro; the slave side is the arbiter.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_ack;
  logic [DATA_W-1:0] ppu_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [BE_W-1:0]   cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [BE_W-1:0]   dma_be;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output ppu_req, ppu_addr,
    input  ppu_ack, ppu_rdata,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_wren, mem_wdata,
    output mem_q
  );

  modport slave (
    input  ppu_req, ppu_addr,
    output ppu_ack, ppu_rdata,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_wren, mem_wdata,
    input  mem_q
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one VRAM read/write port between PPU fetch (highest priority), CPU and DMA.
// Partial-word writes become read-modify-write; a starvation guard bounds CPU/DMA wait.
module vram_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  vram_port_arbiter_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_ACK
  } state_e;

  typedef enum logic [1:0] {
    SRC_PPU,
    SRC_CPU,
    SRC_DMA
  } src_e;

  state_e            state_q,     state_d;
  src_e              owner_q,     owner_d;
  logic [BE_W-1:0]   be_q,        be_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [LAT_W-1:0]  lat_q,       lat_d;
  logic              rr_q,        rr_d;        // 1: DMA preferred on a CPU/DMA tie
  logic [CNT_W-1:0]  starve_q,    starve_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_wren_q,  mem_wren_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        ack_q,       ack_d;       // {dma, cpu, ppu}
  logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              other_req;
  logic              starved;
  logic              pick_dma;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] merged;
  logic              lat_done;
  src_e              grant_src;

  function automatic logic [2:0] src_onehot(input src_e s);
    logic [2:0] r;
    r = '0;
    case (s)
      SRC_PPU: r = 3'b001;
      SRC_CPU: r = 3'b010;
      default: r = 3'b100;
    endcase
    return r;
  endfunction

  // Request selection among CPU/DMA: the one not served last wins a tie.
  always_comb begin
    other_req = bus.cpu_req | bus.dma_req;
    starved   = other_req && (starve_q == CNT_W'(STARVE_MAX));
    pick_dma  = bus.dma_req && (!bus.cpu_req || rr_q);
    sel_we    = pick_dma ? bus.dma_we    : bus.cpu_we;
    sel_be    = pick_dma ? bus.dma_be    : bus.cpu_be;
    sel_addr  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
    sel_wdata = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
    grant_src = pick_dma ? SRC_DMA       : SRC_CPU;
    lat_done  = (lat_q == LAT_W'(READ_LAT));
  end

  always_comb begin
    merged = bus.mem_q;
    for (int i = 0; i < BE_W; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // NOTE: every signal driven here gets a default before the case so that no path
  // leaves it unassigned; a missing default would infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rr_d        = rr_q;
    starve_d    = other_req ? starve_q : '0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    ack_d       = '0;
    ppu_rdata_d = ppu_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        lat_d = '0;
        if (bus.ppu_req && !starved) begin
          owner_d    = SRC_PPU;
          mem_addr_d = bus.ppu_addr;
          state_d    = S_RD_WAIT;
          if (other_req && !starved) starve_d = starve_q + CNT_W'(1);
        end else if (other_req) begin
          owner_d    = grant_src;
          rr_d       = !pick_dma;
          starve_d   = '0;
          mem_addr_d = sel_addr;
          be_d       = sel_be;
          wdata_d    = sel_wdata;
          if (!sel_we) begin
            state_d = S_RD_WAIT;
          end else if (sel_be == '1 || sel_be == '0) begin
            // Whole-word or empty write: one cycle, no read needed.
            state_d     = S_WR;
            mem_wren_d  = |sel_be;
            mem_wdata_d = sel_wdata;
            ack_d       = src_onehot(grant_src);
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end

      S_RD_WAIT: begin
        if (lat_done) begin
          case (owner_q)
            SRC_PPU: ppu_rdata_d = bus.mem_q;
            SRC_CPU: cpu_rdata_d = bus.mem_q;
            default: dma_rdata_d = bus.mem_q;
          endcase
          ack_d   = src_onehot(owner_q);
          state_d = S_ACK;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_RMW_RD: begin
        if (lat_done) begin
          mem_wren_d  = 1'b1;
          mem_wdata_d = merged;
          ack_d       = src_onehot(owner_q);
          state_d     = S_RMW_WR;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      S_WR, S_RMW_WR, S_ACK: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= SRC_PPU;
      be_q        <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      rr_q        <= 1'b0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      ppu_rdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      ppu_rdata_q <= ppu_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.ppu_ack   = ack_q[0];
  assign bus.cpu_ack   = ack_q[1];
  assign bus.dma_ack   = ack_q[2];
  assign bus.ppu_rdata = ppu_rdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
